rr_mux_select_stage: RTL and testbench
======================================

Name: rr_mux_select_stage

Overview:
- Upstream feeder for the 2-level 2:1 mux tree: arbitrates four requesting channels round-robin.
- Latches the winning channel's data into a one-entry output register with valid/ready handshake.
- Publishes the winner index as `out_sel[1:0]`:
  - `out_sel[1]` drives the tree's root select.
  - `out_sel[0]` drives the leaf selects.
- Replaces free-running select wires with a registered, fair, back-pressure-aware source.

Parameters:
- WIDTH, 1, data width of each channel and of `out_data`.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  4  per-channel request; bit i = channel i has a word.
- req_ready  output  4  per-channel accept strobe; at most one bit high per cycle.
- req_data0  input  WIDTH  channel 0 data.
- req_data1  input  WIDTH  channel 1 data.
- req_data2  input  WIDTH  channel 2 data.
- req_data3  input  WIDTH  channel 3 data.
- out_valid  output  1  output register holds a word.
- out_ready  input  1  downstream accepts the word.
- out_data  output  WIDTH  registered data of the granted channel.
- out_sel  output  2  registered index of the granted channel (drives mux tree selects).

Behaviour:
- Reset (async, rst=1):
  - `out_valid`=0, `out_data`=0, `out_sel`=0.
  - Round-robin pointer `ptr`=0, so channel 0 has highest priority first.
  - While rst=1, `req_ready`=0. Reset mid-transfer discards the held word; no partial state survives.
- Load enable: `load = !out_valid || out_ready`. The register is empty, or it is being drained this cycle.
- Arbitration (combinational, evaluated every cycle):
  - Search channels in order `ptr, ptr+1, ptr+2, ptr+3` (mod 4).
  - The first channel with `req_valid`=1 is the winner `g`.
- `req_ready[g]` = `load && any(req_valid)`. All other `req_ready` bits are 0. `req_ready` never depends on `out_ready` except through `load`.
- On a clock edge with `load`=1 and a winner:
  - `out_data` <= `req_data[g]`, `out_sel` <= `g`, `out_valid` <= 1.
  - `ptr` <= `g+1` (mod 4, 2-bit natural wrap: 3 -> 0).
- On `load`=1 with no `req_valid`:
  - `out_valid` <= 0 if draining.
  - `out_data`/`out_sel` hold their last values.
  - `ptr` unchanged.
- Stall (`out_valid`=1, `out_ready`=0):
  - `out_data`, `out_sel`, `out_valid` and `ptr` all hold.
  - All `req_ready`=0.
- Latency: a word accepted at edge N is visible on `out_*` after edge N. One cycle, request to output.
- Throughput: one word per cycle when `out_ready` is held at 1 (simultaneous drain and load).
- Fairness: a continuously requesting channel is granted within 4 accepted transfers.
- Requesters must hold `req_valid`/`req_data` until their `req_ready` is seen high. Dropping `req_valid` early is permitted and simply removes the channel from the next arbitration.
- No combinational path from `out_ready` to `out_data`/`out_sel`/`out_valid`.

Test Plan:
- Reset check: assert rst mid-cycle with `out_valid`=1.
  - Immediately `out_valid`=0, `out_sel`=0, `out_data`=0, `req_ready`=0000.
  - After release, the first grant goes to channel 0 when `req_valid`=1111.
- Round-robin sweep: `req_valid`=1111, data = 0,1,0,1 (WIDTH=1), `out_ready`=1.
  - `out_sel` sequence 0,1,2,3,0,1 on consecutive cycles.
  - `out_data` follows 0,1,0,1,0,1.
  - `req_ready` one-hot rotates 0001, 0010, 0100, 1000.
- Sparse requests with wrap: `ptr`=3, `req_valid`=0101.
  - Grant channel 0 (wrap past 3), then channel 2.
  - `ptr` ends at 3.
- Back-pressure: fill output with channel 1, hold `out_ready`=0 for 5 cycles with `req_valid`=1111.
  - `out_sel`=1 and `out_data` stable; `req_ready`=0000 throughout.
  - On `out_ready`=1, the next grant is channel 2 in the same cycle.
- Idle drain: one word held, `req_valid`=0000, `out_ready`=1.
  - `out_valid` falls to 0 next cycle; `out_sel` holds its last value.
  - `ptr` is unchanged by the idle cycle.
- Mux-tree integration: drive the tree's root select from `out_sel[1]` and its leaf selects from `out_sel[0]`, with leaf inputs a=0, b=1.
  - Tree output equals `out_sel[0]` for all four grant indices.

Source files
------------

// File: rtl/rr_mux_select_stage.sv
// rr_mux_select_stage
// Round-robin arbiter over four requesting channels feeding a one-entry
// registered output stage. The registered winner index drives the select
// lines of a downstream 2-level 2:1 mux tree (out_sel[1] = root select,
// out_sel[0] = leaf selects).
//
// Ports:
//   clk        - clock, rising edge
//   rst        - asynchronous active-high reset
//   req_valid  - per-channel request (bit i = channel i has a word)
//   req_ready  - per-channel accept strobe, at most one bit high
//   req_data0..req_data3 - per-channel data
//   out_valid  - output register holds a word
//   out_ready  - downstream accepts the word
//   out_data   - registered data of the granted channel
//   out_sel    - registered index of the granted channel
module rr_mux_select_stage #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       req_valid,
    output logic [3:0]       req_ready,
    input  logic [WIDTH-1:0] req_data0,
    input  logic [WIDTH-1:0] req_data1,
    input  logic [WIDTH-1:0] req_data2,
    input  logic [WIDTH-1:0] req_data3,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       out_sel
);

    logic [1:0]       ptr_q;
    logic             valid_q;
    logic [WIDTH-1:0] data_q;
    logic [1:0]       sel_q;

    logic             load;
    logic             grant_found;
    logic [1:0]       grant_idx;
    logic [1:0]       cand;
    logic [WIDTH-1:0] grant_data;

    // Register is empty or being drained this cycle.
    assign load = !valid_q || out_ready;

    // Search ptr, ptr+1, ptr+2, ptr+3 with natural 2-bit wrap.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = 2'd0;
        cand        = 2'd0;
        for (int k = 0; k < 4; k++) begin
            cand = ptr_q + 2'(k);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_comb begin
        grant_data = req_data0;
        unique case (grant_idx)
            2'd0: grant_data = req_data0;
            2'd1: grant_data = req_data1;
            2'd2: grant_data = req_data2;
            2'd3: grant_data = req_data3;
            default: grant_data = req_data0;
        endcase
    end

    // Strobes are forced low while reset is held so nothing is consumed.
    always_comb begin
        req_ready = 4'b0000;
        if (!rst && load && grant_found) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q   <= 2'd0;
            valid_q <= 1'b0;
            data_q  <= '0;
            sel_q   <= 2'd0;
        end else if (load) begin
            if (grant_found) begin
                valid_q <= 1'b1;
                data_q  <= grant_data;
                sel_q   <= grant_idx;
                ptr_q   <= grant_idx + 2'd1;
            end else begin
                // Drain with nothing to replace it; data/sel keep last values.
                valid_q <= 1'b0;
            end
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_sel   = sel_q;

endmodule

// File: tb/tb_rr_mux_select_stage.sv
module tb_rr_mux_select_stage;

    localparam int unsigned WIDTH = 1;

    logic             clk;
    logic             rst;
    logic [3:0]       req_valid;
    logic [3:0]       req_ready;
    logic [WIDTH-1:0] req_data0;
    logic [WIDTH-1:0] req_data1;
    logic [WIDTH-1:0] req_data2;
    logic [WIDTH-1:0] req_data3;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       out_sel;

    int ncomp = 0;
    int nfail = 0;

    // Reference model state
    int m_ptr   = 0;
    int m_valid = 0;
    int m_data  = 0;
    int m_sel   = 0;

    rr_mux_select_stage #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data0 (req_data0),
        .req_data1 (req_data1),
        .req_data2 (req_data2),
        .req_data3 (req_data3),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sel   (out_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        ncomp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr = 0; m_valid = 0; m_data = 0; m_sel = 0;
    endtask

    // Mux tree driven by out_sel, leaf inputs a=0 / b=1.
    function automatic int tree_out(input logic [1:0] s);
        logic l0, l1;
        l0 = s[0] ? 1'b1 : 1'b0;
        l1 = s[0] ? 1'b1 : 1'b0;
        return s[1] ? int'(l1) : int'(l0);
    endfunction

    // One cycle: drive inputs, check req_ready, clock, check registered outputs.
    task automatic cycle(input logic [3:0] rv, input logic orr, input logic [3:0] dat,
                         input string tag);
        int g;
        int load;
        int exp_ready;
        req_valid = rv;
        out_ready = orr;
        req_data0 = dat[0];
        req_data1 = dat[1];
        req_data2 = dat[2];
        req_data3 = dat[3];
        #1;
        load = (m_valid == 0 || orr) ? 1 : 0;
        g = -1;
        for (int k = 0; k < 4; k++) begin
            if (g < 0 && rv[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
        end
        exp_ready = (load == 1 && g >= 0) ? (1 << g) : 0;
        chk({tag, ".req_ready"}, int'(req_ready), exp_ready);
        @(posedge clk);
        #1;
        if (load == 1) begin
            if (g >= 0) begin
                m_valid = 1;
                m_data  = int'(dat[g]);
                m_sel   = g;
                m_ptr   = (g + 1) % 4;
            end else begin
                m_valid = 0;
            end
        end
        chk({tag, ".out_valid"}, int'(out_valid), m_valid);
        chk({tag, ".out_sel"}, int'(out_sel), m_sel);
        chk({tag, ".out_data"}, int'(out_data), m_data);
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 4'b1111;
        out_ready = 1'b0;
        req_data0 = '0; req_data1 = '0; req_data2 = '0; req_data3 = '0;
        model_reset();
        #2;
        chk("por.out_valid", int'(out_valid), 0);
        chk("por.req_ready", int'(req_ready), 0);
        rst = 1'b0;

        // Fill register, then assert reset mid-cycle while it is full.
        cycle(4'b0010, 1'b0, 4'b1111, "fill");
        cycle(4'b1111, 1'b0, 4'b1111, "hold");
        rst = 1'b1;
        #1;
        chk("rst.out_valid", int'(out_valid), 0);
        chk("rst.out_sel", int'(out_sel), 0);
        chk("rst.out_data", int'(out_data), 0);
        chk("rst.req_ready", int'(req_ready), 0);
        model_reset();
        #2;
        rst = 1'b0;
        cycle(4'b1111, 1'b1, 4'b1010, "first_after_rst");
        chk("first_after_rst.sel0", int'(out_sel), 0);

        // Round-robin sweep, data 0,1,0,1; also mux-tree integration.
        for (int i = 0; i < 6; i++) begin
            cycle(4'b1111, 1'b1, 4'b1010, "sweep");
            chk("sweep.tree", tree_out(out_sel), m_sel % 2);
        end

        // Sparse requests with wrap: bring ptr to 3, then 0101 -> 0 then 2.
        cycle(4'b0100, 1'b1, 4'b0000, "to_ptr3");
        cycle(4'b0101, 1'b1, 4'b0001, "wrap0");
        chk("wrap0.sel", int'(out_sel), 0);
        cycle(4'b0101, 1'b1, 4'b0100, "wrap2");
        chk("wrap2.sel", int'(out_sel), 2);

        // Back-pressure: load channel 1, stall 5 cycles, then release.
        cycle(4'b0010, 1'b1, 4'b0010, "bp_fill");
        for (int i = 0; i < 5; i++) cycle(4'b1111, 1'b0, 4'b1101, "bp_stall");
        chk("bp_stall.sel", int'(out_sel), 1);
        cycle(4'b1111, 1'b1, 4'b0100, "bp_release");
        chk("bp_release.sel", int'(out_sel), 2);

        // Idle drain then confirm pointer unchanged.
        cycle(4'b0000, 1'b1, 4'b0000, "idle");
        chk("idle.valid", int'(out_valid), 0);
        cycle(4'b1111, 1'b1, 4'b1000, "after_idle");
        chk("after_idle.sel", int'(out_sel), 3);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            cycle(4'($urandom_range(0, 15)), 1'($urandom_range(0, 3) != 0),
                  4'($urandom_range(0, 15)), "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
        $finish;
    end

endmodule
